// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally engine.
package vote_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ARMED  = 2'd1,
    ACK    = 2'd2
  } vote_state_e;

  // Counts set bits; the engine zero-extends its press vector to 32 bits.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/vote_debounce.sv
// Single-channel debouncer: one registered press pulse per stable button hold.
module vote_debounce
  import vote_pkg::*;
#(
  parameter int DEBOUNCE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic button_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LIMIT  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] FIRE_AT = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt_q;
  logic          press_q;

  // Counter parks at LIMIT while held, so the pulse cannot re-fire until release.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= button_i && (cnt_q == FIRE_AT);
      if (!button_i) begin
        cnt_q <= '0;
      end else if (cnt_q < LIMIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/vote_tally_engine.sv
// Ballot-locked voting machine: debounced buttons, saturating tallies,
// indexed readout and leader/tie detection.
module vote_tally_engine
  import vote_pkg::*;
#(
  parameter int NUM_CAND   = 8,
  parameter int CNT_W      = 16,
  parameter int TOT_W      = CNT_W + 5,
  parameter int DEBOUNCE   = 10,
  parameter int ACK_CYCLES = 10,
  parameter int SEL_W      = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_arm,
  input  logic [NUM_CAND-1:0] buttons,
  input  logic [SEL_W-1:0]    sel,
  output logic                ballot_ready,
  output logic                vote_ack,
  output logic                vote_reject,
  output logic [CNT_W-1:0]    sel_count,
  output logic [TOT_W-1:0]    total_votes,
  output logic [SEL_W-1:0]    leader_idx,
  output logic                leader_tie,
  output logic                sat_flag
);

  localparam int AW = $clog2(ACK_CYCLES + 1);
  localparam logic [AW-1:0]    ACK_LOAD = AW'(ACK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);
  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};

  logic [NUM_CAND-1:0] press;
  logic [5:0]          press_cnt;
  logic [SEL_W-1:0]    press_idx;
  logic                vote_en;
  logic                multi_press;

  vote_state_e         state_q;
  logic [AW-1:0]       ack_cnt_q;
  logic                ready_q;
  logic                ack_q;
  logic                reject_q;
  logic [CNT_W-1:0]    tally_q [NUM_CAND];
  logic [TOT_W-1:0]    total_q;
  logic                sat_q;

  logic [CNT_W-1:0]    sel_count_d, sel_count_q;
  logic [SEL_W-1:0]    lead_idx_d, lead_idx_q;
  logic                lead_tie_d, lead_tie_q;
  logic [CNT_W-1:0]    lead_max;
  logic [5:0]          lead_n;

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_deb
    vote_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clock    (clock),
      .reset    (reset),
      .button_i (buttons[g]),
      .press_o  (press[g])
    );
  end

  always_comb begin
    press_cnt   = popcount32(32'(press));
    press_idx   = '0;
    vote_en     = 1'b0;
    multi_press = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (press[i]) press_idx = SEL_W'(i);
    end
    if (state_q == ARMED && !mode) begin
      vote_en     = (press_cnt == 6'd1);
      multi_press = (press_cnt > 6'd1);
    end
  end

  // Ballot FSM together with the tallies it guards; outputs are registered alongside state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LOCKED;
      ack_cnt_q <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      reject_q  <= 1'b0;
      total_q   <= '0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        LOCKED: begin
          if (ballot_arm && !mode) begin
            state_q <= ARMED;
            ready_q <= 1'b1;
          end
        end
        ARMED: begin
          if (mode) begin
            state_q <= LOCKED;
            ready_q <= 1'b0;
          end else if (vote_en) begin
            state_q   <= ACK;
            ready_q   <= 1'b0;
            ack_q     <= 1'b1;
            ack_cnt_q <= ACK_LOAD;
            if (tally_q[press_idx] != CNT_MAX) tally_q[press_idx] <= tally_q[press_idx] + CNT_W'(1);
            if (tally_q[press_idx] >= CNT_NEAR) sat_q <= 1'b1;
            if (total_q != TOT_MAX) total_q <= total_q + TOT_W'(1);
          end else if (multi_press) begin
            reject_q <= 1'b1;
          end
        end
        ACK: begin
          if (ack_cnt_q == AW'(1) || ack_cnt_q == '0) begin
            ack_cnt_q <= '0;
            ack_q     <= 1'b0;
            state_q   <= LOCKED;
          end else begin
            ack_cnt_q <= ack_cnt_q - AW'(1);
          end
        end
        default: begin
          state_q <= LOCKED;
          ready_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Strict '>' keeps the lowest index on ties; all-zero tallies report no tie.
  always_comb begin
    lead_max    = '0;
    lead_idx_d  = '0;
    lead_n      = '0;
    sel_count_d = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] > lead_max) begin
        lead_max   = tally_q[i];
        lead_idx_d = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (tally_q[i] == lead_max) lead_n = lead_n + 6'd1;
    end
    lead_tie_d = (lead_n > 6'd1) && (lead_max != '0);
    if (mode && ({{(32-SEL_W){1'b0}}, sel} < NUM_CAND)) sel_count_d = tally_q[sel];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_count_q <= '0;
      lead_idx_q  <= '0;
      lead_tie_q  <= 1'b0;
    end else begin
      sel_count_q <= sel_count_d;
      lead_idx_q  <= lead_idx_d;
      lead_tie_q  <= lead_tie_d;
    end
  end

  assign ballot_ready = ready_q;
  assign vote_ack     = ack_q;
  assign vote_reject  = reject_q;
  assign sel_count    = sel_count_q;
  assign total_votes  = total_q;
  assign leader_idx   = lead_idx_q;
  assign leader_tie   = lead_tie_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_vote_tally_engine.sv
// Directed and randomized ballots against a transaction-level tally model.
module tb_vote_tally_engine;

  localparam int NC   = 4;
  localparam int CW   = 4;
  localparam int TW   = CW + 5;
  localparam int DEB  = 4;
  localparam int ACKC = 3;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic          ballot_arm = 1'b0;
  logic [NC-1:0] buttons = '0;
  logic [SW-1:0] sel = '0;
  logic          ballot_ready;
  logic          vote_ack;
  logic          vote_reject;
  logic [CW-1:0] sel_count;
  logic [TW-1:0] total_votes;
  logic [SW-1:0] leader_idx;
  logic          leader_tie;
  logic          sat_flag;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int modelTally [NC];
  int modelTotal;
  bit modelSat;
  bit modelArmed;

  int ackCount, rejectCount, ackRiseTick, readyDropTick;

  vote_tally_engine #(
    .NUM_CAND(NC), .CNT_W(CW), .TOT_W(TW), .DEBOUNCE(DEB), .ACK_CYCLES(ACKC), .SEL_W(SW)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm), .buttons(buttons),
    .sel(sel), .ballot_ready(ballot_ready), .vote_ack(vote_ack), .vote_reject(vote_reject),
    .sel_count(sel_count), .total_votes(total_votes), .leader_idx(leader_idx),
    .leader_tie(leader_tie), .sat_flag(sat_flag)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NC; i++) modelTally[i] = 0;
    modelTotal = 0;
    modelSat   = 1'b0;
    modelArmed = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1; ballot_arm = 1'b0; buttons = '0; mode = 1'b0; sel = '0;
    tick();
    tick();
    reset = 1'b0;
    clearModel();
  endtask

  task automatic checkModel(input string tag);
    int best, bestIdx, holders;
    best = 0; bestIdx = 0; holders = 0;
    for (int i = 0; i < NC; i++) if (modelTally[i] > best) begin best = modelTally[i]; bestIdx = i; end
    for (int i = 0; i < NC; i++) if (modelTally[i] == best) holders++;
    checkOutput({tag, ".total"},  32'(total_votes),  32'(modelTotal));
    checkOutput({tag, ".sat"},    32'(sat_flag),     32'(modelSat));
    checkOutput({tag, ".ready"},  32'(ballot_ready), 32'(modelArmed));
    checkOutput({tag, ".leader"}, 32'(leader_idx),   32'(bestIdx));
    checkOutput({tag, ".tie"},    32'(leader_tie),   32'((holders > 1) && (best > 0)));
  endtask

  task automatic checkTally(input string tag, input int k);
    mode = 1'b1;
    sel  = SW'(k);
    tick();
    modelArmed = 1'b0;
    checkOutput({tag, ".selCount"}, 32'(sel_count), 32'(modelTally[k]));
    checkOutput({tag, ".readyAfterResult"}, 32'(ballot_ready), 32'(0));
    mode = 1'b0;
    tick();
    checkOutput({tag, ".selCountVoting"}, 32'(sel_count), 32'(0));
  endtask

  // One ballot transaction: optional arm, hold a button mask, optional arm pulse mid-window.
  task automatic applyStimulus(input string tag, input bit armReq, input logic [NC-1:0] mask,
                               input int hold, input int armAt);
    bit wasReady;
    int pops, k;
    bit pressed, expectVote, expectReject;
    ackCount = 0; rejectCount = 0; ackRiseTick = -1; readyDropTick = -1;
    if (armReq) begin
      ballot_arm = 1'b1;
      tick();
      ballot_arm = 1'b0;
      modelArmed = 1'b1;
    end
    wasReady = ballot_ready;
    buttons  = mask;
    for (int t = 1; t <= hold + DEB + ACKC + 4; t++) begin
      if (t == armAt) ballot_arm = 1'b1;
      tick();
      ballot_arm = 1'b0;
      if (t == hold) buttons = '0;
      if (vote_ack) begin
        ackCount++;
        if (ackRiseTick < 0) ackRiseTick = t;
      end
      if (vote_reject) rejectCount++;
      if (wasReady && !ballot_ready && readyDropTick < 0) readyDropTick = t;
    end
    buttons = '0;

    pops = $countones(mask);
    k = 0;
    for (int i = 0; i < NC; i++) if (mask[i]) k = i;
    pressed      = (hold >= DEB) && (pops > 0);
    expectVote   = modelArmed && pressed && (pops == 1);
    expectReject = modelArmed && pressed && (pops > 1);
    if (expectVote) begin
      modelTally[k] = (modelTally[k] < CMAX) ? modelTally[k] + 1 : CMAX;
      modelTotal    = (modelTotal < TMAX) ? modelTotal + 1 : TMAX;
      if (modelTally[k] == CMAX) modelSat = 1'b1;
      modelArmed = 1'b0;
      checkOutput({tag, ".ackRise"},   32'(ackRiseTick),   32'(DEB + 1));
      checkOutput({tag, ".readyDrop"}, 32'(readyDropTick), 32'(DEB + 1));
    end
    checkOutput({tag, ".ackCycles"}, 32'(ackCount),    32'(expectVote ? ACKC : 0));
    checkOutput({tag, ".rejects"},   32'(rejectCount), 32'(expectReject ? 1 : 0));
    checkModel(tag);
  endtask

  initial begin
    int a, b, r, hold;
    logic [NC-1:0] m;
    bit seen;

    doReset();
    checkOutput("reset.ready",    32'(ballot_ready), 32'(0));
    checkOutput("reset.ack",      32'(vote_ack),     32'(0));
    checkOutput("reset.reject",   32'(vote_reject),  32'(0));
    checkOutput("reset.selCount", 32'(sel_count),    32'(0));
    checkModel("reset");

    applyStimulus("single", 1'b1, 4'b0100, 6, 0);
    checkTally("single", 2);

    applyStimulus("noArm", 1'b0, 4'b0010, 10, 0);
    checkTally("noArm", 1);

    applyStimulus("multi", 1'b1, 4'b1001, 6, 0);
    checkOutput("multi.stillArmed", 32'(ballot_ready), 32'(1));
    applyStimulus("afterMulti", 1'b0, 4'b1000, 6, 0);
    checkTally("afterMulti", 3);

    applyStimulus("longHold", 1'b1, 4'b0010, 20, DEB + 2);
    checkTally("longHold", 1);

    doReset();
    applyStimulus("lead0", 1'b1, 4'b0001, 6, 0);
    applyStimulus("lead2a", 1'b1, 4'b0100, 6, 0);
    applyStimulus("lead2b", 1'b1, 4'b0100, 6, 0);
    mode = 1'b1; sel = 2'd2;
    tick();
    checkOutput("leadA.selCount", 32'(sel_count),  32'(2));
    checkOutput("leadA.idx",      32'(leader_idx), 32'(2));
    checkOutput("leadA.tie",      32'(leader_tie), 32'(0));
    mode = 1'b0;
    tick();
    applyStimulus("lead0b", 1'b1, 4'b0001, 6, 0);
    checkOutput("leadB.idx", 32'(leader_idx), 32'(0));
    checkOutput("leadB.tie", 32'(leader_tie), 32'(1));

    doReset();
    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(9, 0);
      a    = $urandom_range(NC - 1, 0);
      hold = $urandom_range(DEB + 4, DEB - 2);
      m    = '0;
      if (r < 6) begin
        m[a] = 1'b1;
      end else if (r < 9) begin
        b = (a + 1 + $urandom_range(NC - 2, 0)) % NC;
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
      applyStimulus("rand", ($urandom_range(3, 0) != 0), m, hold, 0);
      if (n % 4 == 3) checkTally("randRead", $urandom_range(NC - 1, 0));
    end

    doReset();
    for (int n = 0; n < 16; n++) applyStimulus("sat", 1'b1, 4'b0010, DEB, 0);
    checkTally("sat", 1);
    checkOutput("sat.tally1", 32'(modelTally[1]), 32'(15));
    checkOutput("sat.flag",   32'(sat_flag),      32'(1));
    checkOutput("sat.total",  32'(total_votes),   32'(16));

    ballot_arm = 1'b1;
    tick();
    ballot_arm = 1'b0;
    buttons = 4'b0010;
    seen = 1'b0;
    for (int t = 0; t < 4 * DEB && !seen; t++) begin
      tick();
      if (vote_ack) seen = 1'b1;
    end
    checkOutput("midAck.seen", 32'(seen), 32'(1));
    reset = 1'b1;
    buttons = '0;
    tick();
    checkOutput("midAck.ack",      32'(vote_ack),     32'(0));
    checkOutput("midAck.ready",    32'(ballot_ready), 32'(0));
    checkOutput("midAck.total",    32'(total_votes),  32'(0));
    checkOutput("midAck.sat",      32'(sat_flag),     32'(0));
    checkOutput("midAck.leader",   32'(leader_idx),   32'(0));
    checkOutput("midAck.tie",      32'(leader_tie),   32'(0));
    checkOutput("midAck.selCount", 32'(sel_count),    32'(0));
    reset = 1'b0;
    clearModel();
    tick();
    checkOutput("postReset.ack", 32'(vote_ack), 32'(0));
    checkTally("postReset", 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
